clic_frontend: RTL and testbench
================================

# clic_frontend

Fetch-side PC generator and interrupt injector sitting directly upstream of the CLIC test pipeline. Each cycle it drives the fetch PC and an optional interrupt tag into the pipeline entry. It redirects on trap and xRET notifications from the CSR regfile and issues the pipeline flush. It acknowledges a CLIC interrupt only once the tagged instruction actually traps at retirement.

## Interface
Parameters:
- BOOT_ADDR, 32'h8000_0000: PC value after reset.
- N_STAGES, 3: depth of the downstream pipeline; must match it; range 1..15.
- PC_STEP, 4: sequential PC increment in bytes.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- irq_valid_i  in  1  CLIC interrupt pending.
- irq_i  in  irq_t  interrupt descriptor; opaque to this block; must be held stable while irq_valid_i is high.
- irq_ready_o  out  1  one-cycle acknowledge to CLIC: the interrupt was taken.
- trap_i  in  1  CSR regfile: the retiring instruction traps this cycle.
- trap_vector_i  in  xlen_t  trap target; valid with trap_i.
- eret_i  in  1  CSR regfile: mret/sret retires this cycle.
- epc_i  in  xlen_t  return target; valid with eret_i.
- pc_o  out  xlen_t  fetch PC to the pipeline entry.
- irq_o  out  irq_t  interrupt tag for the instruction at pc_o; '0 when untagged.
- flush_o  out  1  pipeline flush.

## Operation
- PC register pc_q drives pc_o.
  - trap_i: next pc_q = trap_vector_i.
  - else eret_i: next pc_q = epc_i.
  - else: next pc_q = pc_q + PC_STEP.
- Addition wraps modulo 2^XLEN.
- flush_o = trap_i | eret_i, combinational in the same cycle. The entry captured that cycle is discarded downstream.
- trap_i and eret_i high together: trap_i wins for the PC; flush_o is still 1.
- FSM states:
  - RUN: injection allowed. When irq_valid_i is high and there is no trap_i or eret_i this cycle, irq_o = irq_i (tag the current pc_o) and go to INFLIGHT with cnt = 0. Otherwise irq_o = '0.
  - INFLIGHT: irq_o = '0; no new tag is issued; cnt increments each cycle.
    - trap_i: pulse irq_ready_o, go to RUN.
    - eret_i without trap_i: the tagged instruction was flushed; go to RUN with no acknowledge. The interrupt is re-injected later if still pending.
    - See Configuration for the timeout exit.
- trap_i in RUN is an exception, not an interrupt: redirect only, no irq_ready_o.
- irq_ready_o is asserted only in INFLIGHT together with trap_i; it is never asserted in RUN.
- cnt width is $clog2(N_STAGES+1). cnt saturates and does not wrap.

## Timing
- Reset (rst_i sampled high at the edge): pc_q = BOOT_ADDR, state = RUN, cnt = 0.
  - Outputs after reset: pc_o = BOOT_ADDR, irq_o = '0, irq_ready_o = 0, flush_o = 0.
- Reset mid-INFLIGHT discards the pending tag without acknowledge.
- Tag issued in cycle t: the tagged instruction retires at t+N_STAGES, and the expected trap_i is in cycle t+N_STAGES.
- Redirect latency: trap_i or eret_i in cycle t gives pc_o = target in cycle t+1.
- irq_ready_o is combinational from trap_i in INFLIGHT (same cycle). In cycle t+1 the state is RUN. A new injection is possible at t+1 if irq_valid_i is high; the CLIC must drop irq_valid_i in the cycle after irq_ready_o.
- No injection in any cycle with flush_o = 1.

## Configuration
- CLIC_FRONTEND_TIMEOUT_EN defined:
  - INFLIGHT with cnt == N_STAGES and neither trap_i nor eret_i → RUN next cycle, no acknowledge. This covers the regfile declining the interrupt because of privilege or level.
- Not defined:
  - INFLIGHT exits only on trap_i, eret_i or rst_i.
  - cnt logic is not synthesized.

## Test plan
- Reset: hold rst_i 2 cycles, release → pc_o = 0x8000_0000, then 0x8000_0004, 0x8000_0008; irq_o = 0, flush_o = 0, irq_ready_o = 0.
- Interrupt taken: irq_valid_i at cycle 5 with pc_o = 0x8000_0014 → irq_o = irq_i at cycle 5 only. Assert trap_i with trap_vector_i = 0x100 at cycle 8 (N_STAGES = 3) → irq_ready_o = 1 and flush_o = 1 at cycle 8; pc_o = 0x100 at cycle 9.
- Flushed tag: tag at cycle 5, eret_i with epc_i = 0x200 at cycle 6 → no irq_ready_o; pc_o = 0x200 at cycle 7; with irq_valid_i still high, irq_o is re-tagged at cycle 7.
- Simultaneous: trap_i (vector 0x300) and eret_i (epc 0x400) in the same cycle → pc_o = 0x300 next cycle, flush_o = 1 for one cycle.
- Timeout (CLIC_FRONTEND_TIMEOUT_EN): tag at cycle 5, no trap → state RUN at cycle 9, re-tag at cycle 9, irq_ready_o never asserted. Without the macro: no re-tag until trap_i or eret_i arrives.
- Wrap: force pc_q = 0xFFFF_FFFC via trap_vector_i → next pc_o = 0x0000_0000.

Source files
------------

// File: rtl/clic_frontend.sv
// Fetch PC generator and CLIC interrupt injector feeding the pipeline entry.
// Optional feature macro: CLIC_FRONTEND_TIMEOUT_EN (abandon an unacknowledged tag after N_STAGES cycles).
module clic_frontend #(
  parameter int               XLEN      = 32,
  parameter int               IRQ_W     = 16,
  parameter logic [XLEN-1:0]  BOOT_ADDR = 32'h8000_0000,
  parameter int               N_STAGES  = 3,
  parameter int               PC_STEP   = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              irq_valid_i,
  input  logic [IRQ_W-1:0]  irq_i,
  output logic              irq_ready_o,
  input  logic              trap_i,
  input  logic [XLEN-1:0]   trap_vector_i,
  input  logic              eret_i,
  input  logic [XLEN-1:0]   epc_i,
  output logic [XLEN-1:0]   pc_o,
  output logic [IRQ_W-1:0]  irq_o,
  output logic              flush_o
);

  if (N_STAGES < 1 || N_STAGES > 15) begin : g_badStages
    $error("clic_frontend: N_STAGES must be in 1..15");
  end

  typedef enum logic {
    ST_RUN,
    ST_INFLIGHT
  } state_t;

  state_t             r_state;
  state_t             w_nextState;
  logic [XLEN-1:0]    r_pc;
  logic [XLEN-1:0]    w_pcNext;
  logic               w_flush;
  logic               w_inject;
  logic               w_irqReady;
  logic [IRQ_W-1:0]   w_irqTag;

`ifdef CLIC_FRONTEND_TIMEOUT_EN
  localparam int CNT_W = $clog2(N_STAGES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(N_STAGES);

  logic [CNT_W-1:0]   r_cnt;
  logic               w_timeout;

  assign w_timeout = (r_cnt == CNT_MAX);

  // cnt is the distance from the tag cycle: the tag cycle itself is 0, so the
  // first INFLIGHT cycle loads 1 and cnt == N_STAGES is the expected retire cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else if (w_inject) begin
      r_cnt <= CNT_W'(1);
    end else if (r_state == ST_INFLIGHT && !w_timeout) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end
`endif

  assign w_flush = trap_i | eret_i;

  always_comb begin
    w_pcNext = r_pc + XLEN'(PC_STEP);
    if (trap_i) begin
      w_pcNext = trap_vector_i;
    end else if (eret_i) begin
      w_pcNext = epc_i;
    end
  end

  // A tag is never placed on an entry that is being flushed in the same cycle.
  always_comb begin
    w_nextState = r_state;
    w_inject    = 1'b0;
    w_irqReady  = 1'b0;
    w_irqTag    = '0;
    case (r_state)
      ST_RUN: begin
        if (irq_valid_i && !w_flush) begin
          w_inject    = 1'b1;
          w_irqTag    = irq_i;
          w_nextState = ST_INFLIGHT;
        end
      end
      ST_INFLIGHT: begin
        if (trap_i) begin
          w_irqReady  = 1'b1;
          w_nextState = ST_RUN;
        end else if (eret_i) begin
          w_nextState = ST_RUN;
        end
`ifdef CLIC_FRONTEND_TIMEOUT_EN
        else if (w_timeout) begin
          w_nextState = ST_RUN;
        end
`endif
      end
      default: begin
        w_nextState = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_pc    <= BOOT_ADDR;
      r_state <= ST_RUN;
    end else begin
      r_pc    <= w_pcNext;
      r_state <= w_nextState;
    end
  end

  assign pc_o        = r_pc;
  assign irq_o       = w_irqTag;
  assign irq_ready_o = w_irqReady;
  assign flush_o     = w_flush;

endmodule

// File: tb/tb_clic_frontend.sv
// Scoreboard bench for clic_frontend: directed scenarios followed by randomized traffic,
// checked against a cycle-level behavioural model of tag lifetime and PC redirection.
module tb_clic_frontend;

  localparam int XLEN     = 32;
  localparam int IRQ_W    = 16;
  localparam int N_STAGES = 3;
  localparam int PC_STEP  = 4;
  localparam logic [XLEN-1:0] BOOT = 32'h8000_0000;
`ifdef CLIC_FRONTEND_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             irq_valid_i;
  logic [IRQ_W-1:0] irq_i;
  logic             irq_ready_o;
  logic             trap_i;
  logic [XLEN-1:0]  trap_vector_i;
  logic             eret_i;
  logic [XLEN-1:0]  epc_i;
  logic [XLEN-1:0]  pc_o;
  logic [IRQ_W-1:0] irq_o;
  logic             flush_o;

  always #5 clk_i = ~clk_i;

  clic_frontend #(
    .XLEN(XLEN), .IRQ_W(IRQ_W), .BOOT_ADDR(BOOT), .N_STAGES(N_STAGES), .PC_STEP(PC_STEP)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .irq_valid_i(irq_valid_i), .irq_i(irq_i), .irq_ready_o(irq_ready_o),
    .trap_i(trap_i), .trap_vector_i(trap_vector_i),
    .eret_i(eret_i), .epc_i(epc_i),
    .pc_o(pc_o), .irq_o(irq_o), .flush_o(flush_o)
  );

  typedef struct {
    logic [XLEN-1:0]  pc;
    logic [IRQ_W-1:0] irq;
    logic             ready;
    logic             flush;
    int               cyc;
  } expect_t;

  expect_t scoreQ[$];
  int total = 0;
  int bad   = 0;

  // Reference model: an outstanding tag lives from its issue cycle until a
  // redirect (trap acknowledges it, eret drops it) or, with the timeout, until
  // N_STAGES cycles after issue have passed without a redirect.
  logic [XLEN-1:0] mPc;
  bit              mPending;
  int              mTagCycle;
  int              mCycle;
  bit              lastReady;

  task automatic checkOutput(input string name, input int cyc, input logic [XLEN-1:0] act,
                             input logic [XLEN-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s cycle %0d: got %h, expected %h", name, cyc, act, req);
    end
  endtask

  // The monitor pops one expectation per presented cycle, mid-cycle.
  initial begin
    expect_t e;
    forever begin
      @(negedge clk_i);
      if (scoreQ.size() > 0) begin
        e = scoreQ.pop_front();
        checkOutput("pc_o", e.cyc, pc_o, e.pc);
        checkOutput("irq_o", e.cyc, XLEN'(irq_o), XLEN'(e.irq));
        checkOutput("irq_ready_o", e.cyc, XLEN'(irq_ready_o), XLEN'(e.ready));
        checkOutput("flush_o", e.cyc, XLEN'(flush_o), XLEN'(e.flush));
      end
    end
  end

  task automatic applyReset(input int cycles);
    rst_i         = 1'b1;
    irq_valid_i   = 1'b0;
    irq_i         = '0;
    trap_i        = 1'b0;
    trap_vector_i = '0;
    eret_i        = 1'b0;
    epc_i         = '0;
    repeat (cycles) @(posedge clk_i);
    #1;
    rst_i     = 1'b0;
    mPc       = BOOT;
    mPending  = 1'b0;
    mTagCycle = 0;
    mCycle    = 0;
    lastReady = 1'b0;
  endtask

  task automatic applyStimulus(input bit v, input logic [IRQ_W-1:0] irq, input bit tr,
                               input logic [XLEN-1:0] vec, input bit er,
                               input logic [XLEN-1:0] epc);
    bit      inflight;
    bit      flush;
    bit      inject;
    expect_t e;
    irq_valid_i   = v;
    irq_i         = irq;
    trap_i        = tr;
    trap_vector_i = vec;
    eret_i        = er;
    epc_i         = epc;
    inflight = mPending && (!TIMEOUT_EN || (mCycle - mTagCycle) <= N_STAGES);
    flush    = tr | er;
    inject   = !inflight && v && !flush;
    e.pc    = mPc;
    e.irq   = inject ? irq : '0;
    e.ready = inflight && tr;
    e.flush = flush;
    e.cyc   = mCycle;
    scoreQ.push_back(e);
    lastReady = e.ready;
    if (!inflight || flush) mPending = 1'b0;
    if (inject) begin
      mPending  = 1'b1;
      mTagCycle = mCycle;
    end
    mPc = tr ? vec : (er ? epc : mPc + XLEN'(PC_STEP));
    mCycle++;
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, '0);
  endtask

  initial begin
    bit               rv, rt, re, prevV;
    logic [IRQ_W-1:0] irqHold;
    logic [XLEN-1:0]  rvec;

    applyReset(2);
    idle(5);
    // Interrupt taken: tag at cycle 5, trap at cycle 8 acknowledges it.
    applyStimulus(1'b1, 16'hA5A5, 1'b0, '0, 1'b0, '0);
    repeat (2) applyStimulus(1'b1, 16'hA5A5, 1'b0, '0, 1'b0, '0);
    applyStimulus(1'b1, 16'hA5A5, 1'b1, 32'h100, 1'b0, '0);
    idle(3);
    // Flushed tag: eret right after tagging, then re-tag after the redirect.
    applyStimulus(1'b1, 16'h1234, 1'b0, '0, 1'b0, '0);
    applyStimulus(1'b1, 16'h1234, 1'b0, '0, 1'b1, 32'h200);
    repeat (3) applyStimulus(1'b1, 16'h1234, 1'b0, '0, 1'b0, '0);
    applyStimulus(1'b1, 16'h1234, 1'b1, 32'h180, 1'b0, '0);
    idle(2);
    // Simultaneous trap and eret: trap target wins.
    applyStimulus(1'b0, '0, 1'b1, 32'h300, 1'b1, 32'h400);
    idle(2);
    // Held interrupt with no retirement trap.
    repeat (7) applyStimulus(1'b1, 16'h0BEE, 1'b0, '0, 1'b0, '0);
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b1, 32'h500);
    idle(1);
    // PC wrap.
    applyStimulus(1'b0, '0, 1'b1, 32'hFFFF_FFFC, 1'b0, '0);
    idle(3);
    // Reset mid-INFLIGHT drops the tag; a later trap is a plain exception.
    applyStimulus(1'b1, 16'h7777, 1'b0, '0, 1'b0, '0);
    applyStimulus(1'b1, 16'h7777, 1'b0, '0, 1'b0, '0);
    applyReset(1);
    idle(2);
    applyStimulus(1'b0, '0, 1'b1, 32'h640, 1'b0, '0);
    idle(2);

    prevV   = 1'b0;
    irqHold = '0;
    for (int i = 0; i < 3000; i++) begin
      rv = lastReady ? 1'b0 : ($urandom_range(0, 2) != 0);
      if (!prevV) irqHold = IRQ_W'($urandom);
      if (mPending && (mCycle - mTagCycle) == N_STAGES) rt = ($urandom_range(0, 9) < 7);
      else rt = ($urandom_range(0, 19) == 0);
      re   = ($urandom_range(0, 19) == 0);
      rvec = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom;
      applyStimulus(rv, irqHold, rt, rvec, re, $urandom);
      prevV = rv;
    end

    @(negedge clk_i);
    #1;
    total++;
    if (scoreQ.size() != 0) begin
      bad++;
      $display("[TB] FAIL scoreboard drain: got %0d entries left, expected 0", scoreQ.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
